// File: rtl/pdp8_pkg.sv
// Shared PDP-8 fetch/decode types: opcode structs, opcode and op7 code constants, FSM states.
// Optional auto-index support is selected in the decoder with PDP8_AUTO_INDEX_EN.
package pdp8_pkg;

   localparam int ADDR_WIDTH = 12;
   localparam int DATA_WIDTH = 12;

   // Memory-reference opcodes live in IR[11:9]
   localparam logic [2:0] OPC_AND = 3'o0;
   localparam logic [2:0] OPC_TAD = 3'o1;
   localparam logic [2:0] OPC_ISZ = 3'o2;
   localparam logic [2:0] OPC_DCA = 3'o3;
   localparam logic [2:0] OPC_JMS = 3'o4;
   localparam logic [2:0] OPC_JMP = 3'o5;
   localparam logic [2:0] OPC_IOT = 3'o6;
   localparam logic [2:0] OPC_OP7 = 3'o7;

   localparam logic [DATA_WIDTH-1:0] OP7_NOP     = 12'o7000;
   localparam logic [DATA_WIDTH-1:0] OP7_IAC     = 12'o7001;
   localparam logic [DATA_WIDTH-1:0] OP7_RAL     = 12'o7004;
   localparam logic [DATA_WIDTH-1:0] OP7_RTL     = 12'o7006;
   localparam logic [DATA_WIDTH-1:0] OP7_RAR     = 12'o7010;
   localparam logic [DATA_WIDTH-1:0] OP7_RTR     = 12'o7012;
   localparam logic [DATA_WIDTH-1:0] OP7_CML     = 12'o7020;
   localparam logic [DATA_WIDTH-1:0] OP7_CMA     = 12'o7040;
   localparam logic [DATA_WIDTH-1:0] OP7_CIA     = 12'o7041;
   localparam logic [DATA_WIDTH-1:0] OP7_CLL     = 12'o7100;
   localparam logic [DATA_WIDTH-1:0] OP7_CLA1    = 12'o7200;
   localparam logic [DATA_WIDTH-1:0] OP7_CLA_CLL = 12'o7300;
   localparam logic [DATA_WIDTH-1:0] OP7_HLT     = 12'o7402;
   localparam logic [DATA_WIDTH-1:0] OP7_OSR     = 12'o7404;
   localparam logic [DATA_WIDTH-1:0] OP7_SKP     = 12'o7410;
   localparam logic [DATA_WIDTH-1:0] OP7_SNL     = 12'o7420;
   localparam logic [DATA_WIDTH-1:0] OP7_SZL     = 12'o7430;
   localparam logic [DATA_WIDTH-1:0] OP7_SZA     = 12'o7440;
   localparam logic [DATA_WIDTH-1:0] OP7_SNA     = 12'o7450;
   localparam logic [DATA_WIDTH-1:0] OP7_SMA     = 12'o7500;
   localparam logic [DATA_WIDTH-1:0] OP7_SPA     = 12'o7510;
   localparam logic [DATA_WIDTH-1:0] OP7_CLA2    = 12'o7600;

   typedef struct packed {
      logic AND;
      logic TAD;
      logic ISZ;
      logic DCA;
      logic JMS;
      logic JMP;
      logic [ADDR_WIDTH-1:0] mem_inst_addr;
   } pdp_mem_opcode_s;

   typedef struct packed {
      logic NOP;
      logic IAC;
      logic RAL;
      logic RTL;
      logic RAR;
      logic RTR;
      logic CML;
      logic CMA;
      logic CIA;
      logic CLL;
      logic CLA1;
      logic CLA_CLL;
      logic HLT;
      logic OSR;
      logic SKP;
      logic SNL;
      logic SZL;
      logic SZA;
      logic SNA;
      logic SMA;
      logic SPA;
      logic CLA2;
   } pdp_op7_opcode_s;

   typedef enum logic [3:0] {
      IDLE, FETCH_REQ, FETCH_WAIT, DECODE, IND_REQ, IND_WAIT,
      AUTOINC_WR, ISSUE, WAIT_STALL, WAIT_DONE, HALT
   } state_e;

   function automatic pdp_mem_opcode_s mem_decode(input logic [2:0] opc,
                                                  input logic [ADDR_WIDTH-1:0] ea);
      pdp_mem_opcode_s d;
      d = '0;
      case (opc)
         OPC_AND: d.AND = 1'b1;
         OPC_TAD: d.TAD = 1'b1;
         OPC_ISZ: d.ISZ = 1'b1;
         OPC_DCA: d.DCA = 1'b1;
         OPC_JMS: d.JMS = 1'b1;
         OPC_JMP: d.JMP = 1'b1;
         default: d = '0;
      endcase
      d.mem_inst_addr = ea;
      return d;
   endfunction

   // Auto-index locations are 0010-0017
   function automatic logic is_auto_index(input logic [ADDR_WIDTH-1:0] addr);
      return addr[ADDR_WIDTH-1:3] == 9'o001;
   endfunction

endpackage

// File: rtl/instr_decode_if.sv
// Instruction-fetch memory port: one-cycle read/write request pulses, read data one cycle later.
interface instr_decode_if;
   import pdp8_pkg::*;

   logic                  rd_req;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  wr_req;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;

   modport master (output rd_req, rd_addr, wr_req, wr_addr, wr_data, input rd_data);
   modport slave  (input rd_req, rd_addr, wr_req, wr_addr, wr_data, output rd_data);

endinterface

// File: rtl/instr_decode_op7_decoder.sv
// Combinational op7 decode: exact octal match of the full IR, anything unmatched (incl. IOT) is NOP.
module op7_decoder
   import pdp8_pkg::*;
(
   input  logic [DATA_WIDTH-1:0] ir,
   output pdp_op7_opcode_s       op7
);

   always_comb begin
      op7 = '0;
      case (ir)
         OP7_IAC:     op7.IAC     = 1'b1;
         OP7_RAL:     op7.RAL     = 1'b1;
         OP7_RTL:     op7.RTL     = 1'b1;
         OP7_RAR:     op7.RAR     = 1'b1;
         OP7_RTR:     op7.RTR     = 1'b1;
         OP7_CML:     op7.CML     = 1'b1;
         OP7_CMA:     op7.CMA     = 1'b1;
         OP7_CIA:     op7.CIA     = 1'b1;
         OP7_CLL:     op7.CLL     = 1'b1;
         OP7_CLA1:    op7.CLA1    = 1'b1;
         OP7_CLA_CLL: op7.CLA_CLL = 1'b1;
         OP7_HLT:     op7.HLT     = 1'b1;
         OP7_OSR:     op7.OSR     = 1'b1;
         OP7_SKP:     op7.SKP     = 1'b1;
         OP7_SNL:     op7.SNL     = 1'b1;
         OP7_SZL:     op7.SZL     = 1'b1;
         OP7_SZA:     op7.SZA     = 1'b1;
         OP7_SNA:     op7.SNA     = 1'b1;
         OP7_SMA:     op7.SMA     = 1'b1;
         OP7_SPA:     op7.SPA     = 1'b1;
         OP7_CLA2:    op7.CLA2    = 1'b1;
         default:     op7.NOP     = 1'b1;
      endcase
   end

endmodule

// File: rtl/instr_decode.sv
// PDP-8 fetch/decode stage: fetches at PC, resolves the effective address and holds one-hot opcodes.
// Define PDP8_AUTO_INDEX_EN to enable pre-increment of pointers in 0010-0017.
module instr_decode
   import pdp8_pkg::*;
#(
   parameter logic [ADDR_WIDTH-1:0] START_ADDR = 12'o0200
)(
   input  logic                  clk,
   input  logic                  reset,
   output logic [ADDR_WIDTH-1:0] base_addr,
   output pdp_mem_opcode_s       pdp_mem_opcode,
   output pdp_op7_opcode_s       pdp_op7_opcode,
   input  logic                  stall,
   input  logic [ADDR_WIDTH-1:0] PC_value,
   instr_decode_if.master        ifu
);

   state_e                state_reg;
   logic [ADDR_WIDTH-1:0] pc_reg;
   logic [DATA_WIDTH-1:0] ir_reg;
   logic [ADDR_WIDTH-1:0] ea_reg;
   logic                  hlt_reg;
   logic                  rd_req_reg;
   logic [ADDR_WIDTH-1:0] rd_addr_reg;
   pdp_mem_opcode_s       mem_op_reg;
   pdp_op7_opcode_s       op7_op_reg;
   pdp_op7_opcode_s       op7_dec;
   logic [2:0]            opcode;
   logic [ADDR_WIDTH-1:0] ptr_addr;

   assign opcode = ir_reg[11:9];
   // Page bits come from the PC of the instruction held in IR
   assign ptr_addr = ir_reg[7] ? {pc_reg[11:7], ir_reg[6:0]} : {5'b0, ir_reg[6:0]};

   op7_decoder u_op7_decoder (
      .ir  (ir_reg),
      .op7 (op7_dec)
   );

   assign base_addr      = START_ADDR;
   assign pdp_mem_opcode = mem_op_reg;
   assign pdp_op7_opcode = op7_op_reg;
   assign ifu.rd_req     = rd_req_reg;
   assign ifu.rd_addr    = rd_addr_reg;

`ifdef PDP8_AUTO_INDEX_EN
   logic                  wr_req_reg;
   logic [ADDR_WIDTH-1:0] wr_addr_reg;
   logic [DATA_WIDTH-1:0] wr_data_reg;
   logic [DATA_WIDTH-1:0] ptr_inc;

   assign ptr_inc     = ifu.rd_data + 12'd1;
   assign ifu.wr_req  = wr_req_reg;
   assign ifu.wr_addr = wr_addr_reg;
   assign ifu.wr_data = wr_data_reg;
`else
   assign ifu.wr_req  = 1'b0;
   assign ifu.wr_addr = '0;
   assign ifu.wr_data = '0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg   <= IDLE;
         pc_reg      <= START_ADDR;
         ir_reg      <= '0;
         ea_reg      <= '0;
         hlt_reg     <= 1'b0;
         rd_req_reg  <= 1'b0;
         rd_addr_reg <= '0;
         mem_op_reg  <= '0;
         op7_op_reg  <= '0;
`ifdef PDP8_AUTO_INDEX_EN
         wr_req_reg  <= 1'b0;
         wr_addr_reg <= '0;
         wr_data_reg <= '0;
`endif
      end else begin
         // Requests are raised on entry to the request state and last exactly one cycle
         rd_req_reg <= 1'b0;
`ifdef PDP8_AUTO_INDEX_EN
         wr_req_reg <= 1'b0;
`endif
         case (state_reg)
            IDLE: begin
               rd_req_reg  <= 1'b1;
               rd_addr_reg <= pc_reg;
               state_reg   <= FETCH_REQ;
            end
            FETCH_REQ:  state_reg <= FETCH_WAIT;
            FETCH_WAIT: begin
               ir_reg    <= ifu.rd_data;
               state_reg <= DECODE;
            end
            DECODE: begin
               if (opcode < OPC_IOT && ir_reg[8]) begin
                  rd_req_reg  <= 1'b1;
                  rd_addr_reg <= ptr_addr;
                  state_reg   <= IND_REQ;
               end else begin
                  ea_reg    <= ptr_addr;
                  state_reg <= ISSUE;
               end
            end
            IND_REQ: state_reg <= IND_WAIT;
            IND_WAIT: begin
`ifdef PDP8_AUTO_INDEX_EN
               if (is_auto_index(ptr_addr)) begin
                  ea_reg      <= ptr_inc;
                  wr_req_reg  <= 1'b1;
                  wr_addr_reg <= ptr_addr;
                  wr_data_reg <= ptr_inc;
                  state_reg   <= AUTOINC_WR;
               end else begin
                  ea_reg    <= ifu.rd_data;
                  state_reg <= ISSUE;
               end
`else
               ea_reg    <= ifu.rd_data;
               state_reg <= ISSUE;
`endif
            end
`ifdef PDP8_AUTO_INDEX_EN
            AUTOINC_WR: state_reg <= ISSUE;
`endif
            ISSUE: begin
               if (opcode < OPC_IOT) begin
                  mem_op_reg <= mem_decode(opcode, ea_reg);
                  hlt_reg    <= 1'b0;
               end else begin
                  op7_op_reg <= op7_dec;
                  hlt_reg    <= op7_dec.HLT;
               end
               state_reg <= WAIT_STALL;
            end
            WAIT_STALL: begin
               if (stall) state_reg <= WAIT_DONE;
            end
            // Outputs stay valid until execute has finished with them
            WAIT_DONE: begin
               if (!stall) begin
                  mem_op_reg <= '0;
                  op7_op_reg <= '0;
                  pc_reg     <= PC_value;
                  if (hlt_reg) begin
                     state_reg <= HALT;
                  end else begin
                     rd_req_reg  <= 1'b1;
                     rd_addr_reg <= PC_value;
                     state_reg   <= FETCH_REQ;
                  end
               end
            end
            HALT:    state_reg <= HALT;
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_decode.sv
// Directed bench for instr_decode: memory model, decode scoreboard, stall handshake and reset cases.
module tb_instr_decode;
   import pdp8_pkg::*;

   logic                  clk = 1'b0;
   logic                  reset = 1'b1;
   logic                  stall = 1'b0;
   logic [ADDR_WIDTH-1:0] PC_value = '0;
   logic [ADDR_WIDTH-1:0] base_addr;
   pdp_mem_opcode_s       mem_op;
   pdp_op7_opcode_s       op7_op;

   instr_decode_if mem_if ();

   instr_decode #(.START_ADDR(12'o0200)) dut (
      .clk            (clk),
      .reset          (reset),
      .base_addr      (base_addr),
      .pdp_mem_opcode (mem_op),
      .pdp_op7_opcode (op7_op),
      .stall          (stall),
      .PC_value       (PC_value),
      .ifu            (mem_if)
   );

   always #5 clk = ~clk;

   typedef struct {
      pdp_mem_opcode_s m;
      pdp_op7_opcode_s o;
      int              lat;
   } exp_t;

   exp_t                  sb[$];
   logic [11:0]           mem [0:4095];
   logic [11:0]           rd_log[$];
   logic [23:0]           wr_log[$];
   int                    tests = 0;
   int                    fails = 0;
   logic                  prev_rd_req = 1'b0;
   pdp_mem_opcode_s       held_mem;
   pdp_op7_opcode_s       held_op7;

   // Memory model: read data one cycle after the request; writes are logged, not stored
   always @(posedge clk) begin
      if (mem_if.rd_req) begin
         mem_if.rd_data <= mem[mem_if.rd_addr];
         rd_log.push_back(mem_if.rd_addr);
      end
      if (mem_if.wr_req) wr_log.push_back({mem_if.wr_addr, mem_if.wr_data});
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (mem_if.rd_req) check("rd_req_single_cycle", prev_rd_req, 1'b0);
      prev_rd_req <= mem_if.rd_req;
   end

   task automatic start_case(input logic [11:0] instr, input logic [11:0] paddr,
                             input logic [11:0] pval);
      reset = 1'b1;
      stall = 1'b0;
      mem[12'o0200] = instr;
      mem[paddr] = pval;
      repeat (2) @(negedge clk);
      rd_log.delete();
      wr_log.delete();
      reset = 1'b0;
   endtask

   task automatic await_issue(input string tag, input bit req_seen, input logic [11:0] exp_pc);
      exp_t e;
      int   c;
      bit   got;
      got = req_seen;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         got = mem_if.rd_req;
      end
      check({tag, ".req"}, got, 1'b1);
      check({tag, ".fetch_addr"}, mem_if.rd_addr, exp_pc);
      c = 0;
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (mem_op != '0 || op7_op != '0) begin
            got = 1'b1;
            break;
         end
         c++;
      end
      check({tag, ".issued"}, got, 1'b1);
      e = sb.pop_front();
      check({tag, ".latency"}, c, e.lat);
      check({tag, ".mem_op"}, mem_op, e.m);
      check({tag, ".op7_op"}, op7_op, e.o);
      held_mem = e.m;
      held_op7 = e.o;
      $display("[TB] %s: pc=%o mem_op=%h op7_op=%h latency=%0d", tag, exp_pc, mem_op, op7_op, c);
   endtask

   task automatic check_reads(input string tag, input int n, input logic [11:0] a0,
                              input logic [11:0] a1);
      check({tag, ".nreads"}, rd_log.size(), n);
      if (rd_log.size() > 0) check({tag, ".read0"}, rd_log[0], a0);
      if (n > 1 && rd_log.size() > 1) check({tag, ".read1"}, rd_log[1], a1);
   endtask

   task automatic handshake(input string tag, input int hold, input logic [11:0] next_pc,
                            input bit is_hlt);
      int n;
      rd_log.delete();
      stall = 1'b1;
      repeat (hold) begin
         @(negedge clk);
         check({tag, ".held_mem"}, mem_op, held_mem);
         check({tag, ".held_op7"}, op7_op, held_op7);
      end
      stall = 1'b0;
      PC_value = next_pc;
      @(negedge clk);
      check({tag, ".clear_mem"}, mem_op, '0);
      check({tag, ".clear_op7"}, op7_op, '0);
      if (!is_hlt) begin
         check({tag, ".next_req"}, mem_if.rd_req, 1'b1);
         check({tag, ".next_addr"}, mem_if.rd_addr, next_pc);
      end else begin
         n = 0;
         for (int i = 0; i < 20; i++) begin
            if (mem_if.rd_req) n++;
            @(negedge clk);
         end
         check({tag, ".halt_no_req"}, n, 0);
      end
   endtask

   task automatic reset_mid(input int k);
      string tag;
      bit    got;
      tag = $sformatf("rst_mid%0d", k);
      mem[12'o0200] = (k == 5) ? 12'o1410 : 12'o5610;
      mem[12'o0010] = 12'o0777;
      mem[12'o0210] = 12'o4000;
      reset = 1'b1;
      stall = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         got = mem_if.rd_req;
      end
      repeat (k) @(negedge clk);
      if (k == 3) check({tag, ".rd_req_before"}, mem_if.rd_req, 1'b1);
      if (k == 5) check({tag, ".wr_req_before"}, mem_if.wr_req, 1'b1);
      reset = 1'b1;
      #1;
      check({tag, ".rd_req"}, mem_if.rd_req, 1'b0);
      check({tag, ".wr_req"}, mem_if.wr_req, 1'b0);
      check({tag, ".mem_op"}, mem_op, '0);
      check({tag, ".op7_op"}, op7_op, '0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         got = mem_if.rd_req;
      end
      check({tag, ".restart_req"}, got, 1'b1);
      check({tag, ".restart_addr"}, mem_if.rd_addr, 12'o0200);
      $display("[TB] %s: reset applied %0d cycles after fetch, restarted at %o", tag, k, mem_if.rd_addr);
   endtask

   initial begin
      pdp_mem_opcode_s em;
      pdp_op7_opcode_s eo;
      int              ind_lat;
      for (int i = 0; i < 4096; i++) mem[i] = 12'o0;

      repeat (2) @(negedge clk);
      check("reset.rd_req", mem_if.rd_req, 1'b0);
      check("reset.wr_req", mem_if.wr_req, 1'b0);
      check("reset.mem_op", mem_op, '0);
      check("reset.op7_op", op7_op, '0);
      check("reset.base_addr", base_addr, 12'o0200);
      $display("[TB] reset: outputs idle, base_addr=%o", base_addr);

      // Direct current page, then chained fetch into another page
      em = '0; em.TAD = 1'b1; em.mem_inst_addr = 12'o0205; eo = '0;
      sb.push_back('{m: em, o: eo, lat: 3});
      mem[12'o0400] = 12'o1205;
      start_case(12'o1205, 12'o0400, 12'o1205);
      await_issue("direct_cur", 1'b0, 12'o0200);
      check_reads("direct_cur", 1, 12'o0200, 12'o0);
      em.mem_inst_addr = 12'o0405;
      sb.push_back('{m: em, o: eo, lat: 3});
      handshake("direct_cur", 1, 12'o0400, 1'b0);
      await_issue("direct_page4", 1'b1, 12'o0400);
      handshake("direct_page4", 3, 12'o0401, 1'b0);

      em = '0; em.TAD = 1'b1; em.mem_inst_addr = 12'o0005;
      sb.push_back('{m: em, o: eo, lat: 3});
      start_case(12'o1005, 12'o0005, 12'o0);
      await_issue("direct_zero", 1'b0, 12'o0200);

      em = '0; em.JMP = 1'b1; em.mem_inst_addr = 12'o4000;
      sb.push_back('{m: em, o: eo, lat: 5});
      start_case(12'o5610, 12'o0210, 12'o4000);
      await_issue("indirect_cur", 1'b0, 12'o0200);
      check_reads("indirect_cur", 2, 12'o0200, 12'o0210);

`ifdef PDP8_AUTO_INDEX_EN
      ind_lat = 6;
      em = '0; em.TAD = 1'b1; em.mem_inst_addr = 12'o1000;
`else
      ind_lat = 5;
      em = '0; em.TAD = 1'b1; em.mem_inst_addr = 12'o0777;
`endif
      sb.push_back('{m: em, o: eo, lat: ind_lat});
      start_case(12'o1410, 12'o0010, 12'o0777);
      await_issue("auto_index", 1'b0, 12'o0200);
      check_reads("auto_index", 2, 12'o0200, 12'o0010);
`ifdef PDP8_AUTO_INDEX_EN
      check("auto_index.nwrites", wr_log.size(), 1);
      if (wr_log.size() > 0) check("auto_index.write", wr_log[0], {12'o0010, 12'o1000});
      em.mem_inst_addr = 12'o0000;
`else
      check("auto_index.nwrites", wr_log.size(), 0);
      em.mem_inst_addr = 12'o7777;
`endif
      sb.push_back('{m: em, o: eo, lat: ind_lat});
      start_case(12'o1410, 12'o0010, 12'o7777);
      await_issue("auto_wrap", 1'b0, 12'o0200);
`ifdef PDP8_AUTO_INDEX_EN
      check("auto_wrap.nwrites", wr_log.size(), 1);
      if (wr_log.size() > 0) check("auto_wrap.write", wr_log[0], {12'o0010, 12'o0000});
`else
      check("auto_wrap.nwrites", wr_log.size(), 0);
`endif

      // Op7 / IOT decode; reset while the flags are held must clear them at once
      em = '0;
      eo = '0; eo.CLA_CLL = 1'b1;
      sb.push_back('{m: em, o: eo, lat: 3});
      start_case(12'o7300, 12'o0001, 12'o0);
      await_issue("op7_cla_cll", 1'b0, 12'o0200);
      reset = 1'b1;
      #1;
      check("op7_cla_cll.reset_clear", op7_op, '0);

      eo = '0; eo.NOP = 1'b1;
      sb.push_back('{m: em, o: eo, lat: 3});
      start_case(12'o7777, 12'o0001, 12'o0);
      await_issue("op7_unmatched", 1'b0, 12'o0200);

      sb.push_back('{m: em, o: eo, lat: 3});
      start_case(12'o6031, 12'o0001, 12'o0);
      await_issue("iot", 1'b0, 12'o0200);

      eo = '0; eo.IAC = 1'b1;
      sb.push_back('{m: em, o: eo, lat: 3});
      start_case(12'o7001, 12'o0001, 12'o0);
      await_issue("op7_iac", 1'b0, 12'o0200);

      eo = '0; eo.CLA2 = 1'b1;
      sb.push_back('{m: em, o: eo, lat: 3});
      start_case(12'o7600, 12'o0001, 12'o0);
      await_issue("op7_cla2", 1'b0, 12'o0200);

      eo = '0; eo.HLT = 1'b1;
      sb.push_back('{m: em, o: eo, lat: 3});
      start_case(12'o7402, 12'o0001, 12'o0);
      await_issue("op7_hlt", 1'b0, 12'o0200);
      handshake("op7_hlt", 2, 12'o0201, 1'b1);

      reset_mid(3);
      reset_mid(4);
`ifdef PDP8_AUTO_INDEX_EN
      reset_mid(5);
`endif
      check("scoreboard_empty", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

endmodule
